// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared constants and entry type for the mips32 fetch stage
package fetch_queue_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] FQ_RESET_PC = '0;
    localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - imem, decode and redirect signals of the fetch stage
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int ADDR_W = WORD_W,
    parameter int DATA_W = WORD_W
) ();

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_rdata, inst_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_rdata, inst_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_queue_fifo.sv
// rtl/fetch_queue_fifo.sv - DEPTH-entry sync FIFO with flush, count and registered head
module fetch_queue_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2 * WORD_W,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [W-1:0]  head_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    assign do_pop = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_i) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - mips32 fetch PC, imem request/credit logic and instruction queue (FETCH_QUEUE_PERF_EN adds perf counters)
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = WORD_W,
    parameter int                DATA_W   = WORD_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FQ_RESET_PC)
) (
    input  logic        clk,
    input  logic        reset,
    fetch_queue_if.master fq
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]        inflight_pc_q, inflight_pc_d;
    logic                     inflight_q, inflight_d;
    logic [CW-1:0]            count;
    logic                     credit, req, push, pop;
    logic [DATA_W+ADDR_W-1:0] head;

    // Credit counts the outstanding response; a same-cycle pop frees nothing yet.
    assign credit = ({1'b0, count} + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH);
    assign req    = !reset && !fq.redirect && credit;
    assign push   = inflight_q && !fq.redirect;
    assign pop    = fq.inst_valid && fq.inst_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        if (fq.redirect) begin
            fetch_pc_d = fq.redirect_pc;
        end else if (req) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    fetch_queue_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_W + ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i ({fq.imem_rdata, inflight_pc_q}),
        .pop_i       (pop),
        .flush_i     (fq.redirect),
        .head_o      (head),
        .valid_o     (fq.inst_valid),
        .count_o     (count)
    );

    assign fq.imem_req  = req;
    assign fq.imem_addr = fetch_pc_q;
    assign fq.inst      = head[ADDR_W +: DATA_W];
    assign fq.inst_pc   = head[ADDR_W-1:0];

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (fq.inst_valid && !fq.inst_ready && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (fq.redirect && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) fq ();

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    fetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (fq)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: mem[a] = 32'h1000_0000 + a, one-cycle read latency.
    always @(posedge clk) fq.imem_rdata <= 32'h1000_0000 + fq.imem_addr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        fq.inst_ready  = 1'b0;
        fq.redirect    = 1'b0;
        fq.redirect_pc = 32'h0;
        repeat (3) tick();
        settle();
        chk("rst_req",   64'(fq.imem_req),   64'h0);
        chk("rst_valid", 64'(fq.inst_valid), 64'h0);
        chk("rst_inst",  64'(fq.inst),       64'h0);
        chk("rst_pc",    64'(fq.inst_pc),    64'h0);
`ifdef FETCH_QUEUE_PERF_EN
        chk("rst_perf_stall", 64'(perf_stall_cnt), 64'h0);
        chk("rst_perf_flush", 64'(perf_flush_cnt), 64'h0);
`endif

        // Streaming with decode always ready
        reset = 1'b0;
        fq.inst_ready = 1'b1;
        settle();
        chk("s_req0",  64'(fq.imem_req),  64'h1);
        chk("s_addr0", 64'(fq.imem_addr), 64'h0);
        tick(); settle();
        chk("s_req1",   64'(fq.imem_req),   64'h1);
        chk("s_addr1",  64'(fq.imem_addr),  64'h1);
        chk("s_valid1", 64'(fq.inst_valid), 64'h0);
        tick(); settle();
        chk("s_valid2", 64'(fq.inst_valid), 64'h1);
        chk("s_pc2",    64'(fq.inst_pc),    64'h0);
        chk("s_inst2",  64'(fq.inst),       64'h1000_0000);
        for (int i = 1; i <= 5; i++) begin
            tick(); settle();
            chk("s_valid", 64'(fq.inst_valid), 64'h1);
            chk("s_pc",    64'(fq.inst_pc),    64'(i));
        end

        // Backpressure fills the queue
        reset = 1'b1;
        fq.inst_ready = 1'b0;
        tick();
        reset = 1'b0;
        settle();
        repeat (9) tick();
        settle();
        chk("full_req",   64'(fq.imem_req),   64'h0);
        chk("full_addr",  64'(fq.imem_addr),  64'h4);
        chk("full_valid", 64'(fq.inst_valid), 64'h1);
        chk("full_pc",    64'(fq.inst_pc),    64'h0);
        fq.inst_ready = 1'b1;
        settle();
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", 64'(fq.inst_valid), 64'h1);
            chk("drain_pc",    64'(fq.inst_pc),    64'(i));
            chk("drain_inst",  64'(fq.inst),       64'(32'h1000_0000 + i));
            tick(); settle();
        end

        // Redirect with a request in flight
        fq.redirect    = 1'b1;
        fq.redirect_pc = 32'h40;
        settle();
        chk("rd_req_t", 64'(fq.imem_req), 64'h0);
        tick();
        fq.redirect = 1'b0;
        settle();
        chk("rd_req_t1",   64'(fq.imem_req),   64'h1);
        chk("rd_addr_t1",  64'(fq.imem_addr),  64'h40);
        chk("rd_valid_t1", 64'(fq.inst_valid), 64'h0);
        tick(); settle();
        chk("rd_valid_t2", 64'(fq.inst_valid), 64'h0);
        tick(); settle();
        chk("rd_valid_t3", 64'(fq.inst_valid), 64'h1);
        chk("rd_pc_t3",    64'(fq.inst_pc),    64'h40);
        chk("rd_inst_t3",  64'(fq.inst),       64'h1000_0040);
        tick(); settle();
        chk("rd_pc_t4", 64'(fq.inst_pc), 64'h41);

        // Redirect and pop together while full
        fq.inst_ready = 1'b0;
        repeat (8) tick();
        settle();
        chk("rf_full_req",  64'(fq.imem_req),  64'h0);
        chk("rf_full_addr", 64'(fq.imem_addr), 64'h45);
        chk("rf_full_pc",   64'(fq.inst_pc),   64'h41);
        fq.inst_ready  = 1'b1;
        fq.redirect    = 1'b1;
        fq.redirect_pc = 32'h80;
        settle();
        chk("rf_req_t", 64'(fq.imem_req), 64'h0);
        tick();
        fq.redirect = 1'b0;
        settle();
        chk("rf_valid_t1", 64'(fq.inst_valid), 64'h0);
        chk("rf_addr_t1",  64'(fq.imem_addr),  64'h80);
        tick(); settle();
        chk("rf_valid_t2", 64'(fq.inst_valid), 64'h0);
        tick(); settle();
        chk("rf_valid_t3", 64'(fq.inst_valid), 64'h1);
        chk("rf_pc_t3",    64'(fq.inst_pc),    64'h80);
        tick(); settle();
        chk("rf_pc_t4", 64'(fq.inst_pc), 64'h81);

        // PC wrap at the top of the address space
        fq.redirect    = 1'b1;
        fq.redirect_pc = 32'hFFFF_FFFF;
        tick();
        fq.redirect = 1'b0;
        settle();
        chk("wr_addr_t1", 64'(fq.imem_addr), 64'hFFFF_FFFF);
        tick(); settle();
        chk("wr_req_t2",  64'(fq.imem_req),  64'h1);
        chk("wr_addr_t2", 64'(fq.imem_addr), 64'h0);
        tick(); settle();
        chk("wr_pc_t3",   64'(fq.inst_pc), 64'hFFFF_FFFF);
        chk("wr_inst_t3", 64'(fq.inst),    64'h0FFF_FFFF);
        tick(); settle();
        chk("wr_pc_t4",   64'(fq.inst_pc), 64'h0);
        chk("wr_inst_t4", 64'(fq.inst),    64'h1000_0000);

        // Reset mid-stream with a response outstanding
        reset = 1'b1;
        tick(); settle();
        chk("mr_valid", 64'(fq.inst_valid), 64'h0);
        chk("mr_req",   64'(fq.imem_req),   64'h0);
        chk("mr_pc",    64'(fq.inst_pc),    64'h0);
        reset = 1'b0;
        settle();
        chk("mr_req_r0",  64'(fq.imem_req),  64'h1);
        chk("mr_addr_r0", 64'(fq.imem_addr), 64'h0);
        tick(); tick(); settle();
        chk("mr_valid_r2", 64'(fq.inst_valid), 64'h1);
        chk("mr_pc_r2",    64'(fq.inst_pc),    64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
